// File: rtl/mmu_tlb_assoc_if.sv
// Request/response and management-command bundle for the fully-associative TLB.
// Signal names match the block's flat port list.
interface mmu_tlb_assoc_if #(
  parameter int unsigned IDX_W = 4
);
  logic             req_valid;
  logic [31:0]      req_addr;
  logic             req_write;
  logic [7:0]       asid_i;
  logic             resp_valid;
  logic [31:0]      resp_paddr;
  logic             exc_tlbl;
  logic             exc_tlbs;
  logic             exc_tlbm;
  logic             exc_refill;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_index;
  logic [IDX_W-1:0] wired_i;
  logic [31:0]      entryhi_i;
  logic [31:0]      entrylo0_i;
  logic [31:0]      entrylo1_i;
  logic             cmd_done;
  logic [31:0]      probe_o;
  logic [31:0]      rd_entryhi_o;
  logic [31:0]      rd_entrylo0_o;
  logic [31:0]      rd_entrylo1_o;
  logic [IDX_W-1:0] random_o;

  modport slave (
    input  req_valid, req_addr, req_write, asid_i,
    input  cmd_valid, cmd_op, cmd_index, wired_i, entryhi_i, entrylo0_i, entrylo1_i,
    output resp_valid, resp_paddr, exc_tlbl, exc_tlbs, exc_tlbm, exc_refill,
    output cmd_done, probe_o, rd_entryhi_o, rd_entrylo0_o, rd_entrylo1_o, random_o
  );

  modport master (
    output req_valid, req_addr, req_write, asid_i,
    output cmd_valid, cmd_op, cmd_index, wired_i, entryhi_i, entrylo0_i, entrylo1_i,
    input  resp_valid, resp_paddr, exc_tlbl, exc_tlbs, exc_tlbm, exc_refill,
    input  cmd_done, probe_o, rd_entryhi_o, rd_entrylo0_o, rd_entrylo1_o, random_o
  );
endinterface

// File: rtl/mmu_tlb_assoc.sv
// Fully-associative MIPS-style TLB: single-cycle lookup with exception
// classification, plus TLBWI/TLBWR/TLBP/TLBR management and a wired Random counter.
module mmu_tlb_assoc #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input logic           clk,
  input logic           rst,
  mmu_tlb_assoc_if.slave bus
);
  localparam int unsigned VPN_W  = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic [1:0] {
    OP_TLBWI = 2'b00,
    OP_TLBWR = 2'b01,
    OP_TLBP  = 2'b10,
    OP_TLBR  = 2'b11
  } cmd_op_e;

  logic [VPN_W-1:0]  vpn2_q [ENTRIES];
  logic [ASID_W-1:0] asid_q [ENTRIES];
  logic [PFN_W-1:0]  pfn0_q [ENTRIES];
  logic [PFN_W-1:0]  pfn1_q [ENTRIES];
  logic [ENTRIES-1:0] g_q, d0_q, v0_q, d1_q, v1_q;

  logic [IDX_W-1:0] random_q, random_d, wired_q;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_paddr_q, resp_paddr_d;
  logic             tlbl_q, tlbl_d, tlbs_q, tlbs_d, tlbm_q, tlbm_d, refill_q, refill_d;
  logic             cmd_done_q;
  logic [31:0]      probe_q, rd_hi_q, rd_lo0_q, rd_lo1_q;

  logic             l_hit, p_hit;
  logic [IDX_W-1:0] l_idx, p_idx, w_idx;
  logic             we;
  logic [PFN_W-1:0] sel_pfn;
  logic             sel_d, sel_v;
  cmd_op_e          op;

  assign op = cmd_op_e'(bus.cmd_op);

  // Lookup and probe searches; descending scan leaves the lowest matching index.
  always_comb begin
    l_hit = 1'b0;
    l_idx = '0;
    p_hit = 1'b0;
    p_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (vpn2_q[IDX_W'(i)] == bus.req_addr[31:13] &&
          (g_q[IDX_W'(i)] || asid_q[IDX_W'(i)] == bus.asid_i)) begin
        l_hit = 1'b1;
        l_idx = IDX_W'(i);
      end
      if (vpn2_q[IDX_W'(i)] == bus.entryhi_i[31:13] &&
          (g_q[IDX_W'(i)] || asid_q[IDX_W'(i)] == bus.entryhi_i[7:0])) begin
        p_hit = 1'b1;
        p_idx = IDX_W'(i);
      end
    end
  end

  // Translation result and exception classification for the sampled request.
  always_comb begin
    resp_valid_d = bus.req_valid;
    resp_paddr_d = '0;
    tlbl_d       = 1'b0;
    tlbs_d       = 1'b0;
    tlbm_d       = 1'b0;
    refill_d     = 1'b0;
    sel_pfn      = bus.req_addr[12] ? pfn1_q[l_idx] : pfn0_q[l_idx];
    sel_d        = bus.req_addr[12] ? d1_q[l_idx]   : d0_q[l_idx];
    sel_v        = bus.req_addr[12] ? v1_q[l_idx]   : v0_q[l_idx];
    if (bus.req_valid) begin
      if (bus.req_addr[31:30] == 2'b10) begin
        resp_paddr_d = {3'b000, bus.req_addr[28:0]};
      end else if (!l_hit || !sel_v) begin
        refill_d = !l_hit;
        tlbs_d   = bus.req_write;
        tlbl_d   = !bus.req_write;
      end else if (bus.req_write && !sel_d) begin
        tlbm_d = 1'b1;
      end else begin
        resp_paddr_d = {sel_pfn, bus.req_addr[11:0]};
      end
    end
  end

  // Random counts down toward wired and restarts at the top on wrap or wired change.
  always_comb begin
    random_d = random_q - 1'b1;
    if (bus.wired_i >= LAST_IDX || bus.wired_i != wired_q || random_q <= bus.wired_i) begin
      random_d = LAST_IDX;
    end
  end

  assign we    = bus.cmd_valid && (op == OP_TLBWI || op == OP_TLBWR);
  assign w_idx = (op == OP_TLBWR) ? random_q : bus.cmd_index;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        vpn2_q[IDX_W'(i)] <= '0;
        asid_q[IDX_W'(i)] <= '0;
        pfn0_q[IDX_W'(i)] <= '0;
        pfn1_q[IDX_W'(i)] <= '0;
      end
      g_q          <= '0;
      d0_q         <= '0;
      v0_q         <= '0;
      d1_q         <= '0;
      v1_q         <= '0;
      random_q     <= LAST_IDX;
      wired_q      <= bus.wired_i;
      resp_valid_q <= 1'b0;
      resp_paddr_q <= '0;
      tlbl_q       <= 1'b0;
      tlbs_q       <= 1'b0;
      tlbm_q       <= 1'b0;
      refill_q     <= 1'b0;
      cmd_done_q   <= 1'b0;
      probe_q      <= 32'h8000_0000;
      rd_hi_q      <= '0;
      rd_lo0_q     <= '0;
      rd_lo1_q     <= '0;
    end else begin
      random_q     <= random_d;
      wired_q      <= bus.wired_i;
      resp_valid_q <= resp_valid_d;
      resp_paddr_q <= resp_paddr_d;
      tlbl_q       <= tlbl_d;
      tlbs_q       <= tlbs_d;
      tlbm_q       <= tlbm_d;
      refill_q     <= refill_d;
      cmd_done_q   <= bus.cmd_valid;
      if (we) begin
        vpn2_q[w_idx] <= bus.entryhi_i[31:13];
        asid_q[w_idx] <= bus.entryhi_i[7:0];
        pfn0_q[w_idx] <= bus.entrylo0_i[25:6];
        pfn1_q[w_idx] <= bus.entrylo1_i[25:6];
        g_q[w_idx]    <= bus.entrylo0_i[0] & bus.entrylo1_i[0];
        d0_q[w_idx]   <= bus.entrylo0_i[2];
        v0_q[w_idx]   <= bus.entrylo0_i[1];
        d1_q[w_idx]   <= bus.entrylo1_i[2];
        v1_q[w_idx]   <= bus.entrylo1_i[1];
      end
      if (bus.cmd_valid && op == OP_TLBP) begin
        if (p_hit) probe_q <= {1'b0, (31 - IDX_W)'(0), p_idx};
        else       probe_q[31] <= 1'b1;
      end
      if (bus.cmd_valid && op == OP_TLBR) begin
        rd_hi_q  <= {vpn2_q[bus.cmd_index], 5'b0, asid_q[bus.cmd_index]};
        rd_lo0_q <= {6'b0, pfn0_q[bus.cmd_index], 3'b0, d0_q[bus.cmd_index],
                     v0_q[bus.cmd_index], g_q[bus.cmd_index]};
        rd_lo1_q <= {6'b0, pfn1_q[bus.cmd_index], 3'b0, d1_q[bus.cmd_index],
                     v1_q[bus.cmd_index], g_q[bus.cmd_index]};
      end
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_paddr    = resp_paddr_q;
  assign bus.exc_tlbl      = tlbl_q;
  assign bus.exc_tlbs      = tlbs_q;
  assign bus.exc_tlbm      = tlbm_q;
  assign bus.exc_refill    = refill_q;
  assign bus.cmd_done      = cmd_done_q;
  assign bus.probe_o       = probe_q;
  assign bus.rd_entryhi_o  = rd_hi_q;
  assign bus.rd_entrylo0_o = rd_lo0_q;
  assign bus.rd_entrylo1_o = rd_lo1_q;
  assign bus.random_o      = random_q;

  // Reserved EntryHi/EntryLo fields carry no state.
  logic unused_bits;
  assign unused_bits = ^{bus.entryhi_i[12:8], bus.entrylo0_i[31:26], bus.entrylo0_i[5:3],
                         bus.entrylo1_i[31:26], bus.entrylo1_i[5:3]};
endmodule
